// File: rtl/hazard_predict_unit_pkg.sv
// Shared encodings and helpers for the hazard/forwarding unit and its branch predictor.
// Used by hazard_predict_unit and bpred_table.
package hazard_predict_unit_pkg;

    typedef enum logic [1:0] {
        BRMUX_SEQ      = 2'b00,
        BRMUX_TARGET   = 2'b01,
        BRMUX_FALLTHRU = 2'b10
    } brmux_e;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_RESULTW = 2'b01,
        FWD_ALUOUTM = 2'b10
    } fwd_e;

    // Weakly not-taken: one taken branch is enough to flip the prediction.
    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    function automatic fwd_e fwd_sel(input logic [4:0] src,
                                     input logic       regwrite_m,
                                     input logic [4:0] writereg_m,
                                     input logic       regwrite_w,
                                     input logic [4:0] writereg_w);
        if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src)) begin
            return FWD_ALUOUTM;
        end
        if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src)) begin
            return FWD_RESULTW;
        end
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hazard_predict_unit_bpred_table.sv
// Table of 2-bit saturating branch counters, indexed by low PC bits.
// Read is combinational and sees the value before any same-cycle update.
module bpred_table
    import hazard_predict_unit_pkg::*;
#(
    parameter int IDXW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_taken,
    input  logic            upd_en,
    input  logic [IDXW-1:0] upd_idx,
    input  logic            upd_taken
);

    localparam int ENTRIES = 1 << IDXW;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = sat_update(ctr_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/hazard_predict_unit.sv
// Pipeline hazard unit: forwarding selects, load-use and branch stalls,
// plus a 2-bit branch predictor resolved one stage later in E.
module hazard_predict_unit
    import hazard_predict_unit_pkg::*;
#(
    parameter int IDXW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rsD,
    input  logic [4:0]      rtD,
    input  logic [4:0]      rsE,
    input  logic [4:0]      rtE,
    input  logic [4:0]      writeregE,
    input  logic [4:0]      writeregM,
    input  logic [4:0]      writeregW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            branchD,
    input  logic            equalD,
    input  logic [IDXW-1:0] pcD,
    output logic            stallF,
    output logic            stallD,
    output logic            flushD,
    output logic            flushE,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            brbitF,
    output logic            branchCorrect,
    output logic [1:0]      brmuxsel
);

    logic            lwstall;
    logic            brstall;
    logic            mispredict;
    logic            pred_taken;
    logic            branch_e_q, branch_e_d;
    logic            pred_e_q,   pred_e_d;
    logic            taken_e_q,  taken_e_d;
    logic [IDXW-1:0] idx_e_q,    idx_e_d;

    always_comb begin
        forwardAE = fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
        forwardBE = fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
        forwardAD = regwriteM && (writeregM != 5'd0) && (writeregM == rsD);
        forwardBD = regwriteM && (writeregM != 5'd0) && (writeregM == rtD);
    end

    // A branch in D compares in D, so it must wait for any result still in E or a load in M.
    always_comb begin
        lwstall = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
        brstall = branchD &&
                  ((regwriteE && (writeregE != 5'd0) &&
                    ((writeregE == rsD) || (writeregE == rtD))) ||
                   (memtoregM && (writeregM != 5'd0) &&
                    ((writeregM == rsD) || (writeregM == rtD))));
    end

    assign mispredict    = branch_e_q && (pred_e_q != taken_e_q);
    assign branchCorrect = branch_e_q && !mispredict;

    // A mispredict squashes the wrong-path instructions, so it overrides any stall.
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        brmuxsel = BRMUX_SEQ;
        if (mispredict) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            brmuxsel = taken_e_q ? BRMUX_TARGET : BRMUX_FALLTHRU;
        end else begin
            stallF = lwstall || brstall;
            stallD = lwstall || brstall;
            flushE = lwstall || brstall;
        end
    end

    assign brbitF = branchD && pred_taken && !stallD && !mispredict;

    always_comb begin
        branch_e_d = branch_e_q;
        pred_e_d   = pred_e_q;
        taken_e_d  = taken_e_q;
        idx_e_d    = idx_e_q;
        if (flushE) begin
            branch_e_d = 1'b0;
        end else if (!stallD) begin
            branch_e_d = branchD;
            pred_e_d   = brbitF;
            taken_e_d  = equalD;
            idx_e_d    = pcD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_e_q <= 1'b0;
            pred_e_q   <= 1'b0;
            taken_e_q  <= 1'b0;
            idx_e_q    <= '0;
        end else begin
            branch_e_q <= branch_e_d;
            pred_e_q   <= pred_e_d;
            taken_e_q  <= taken_e_d;
            idx_e_q    <= idx_e_d;
        end
    end

    bpred_table #(
        .IDXW(IDXW)
    ) u_bpred_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pcD),
        .rd_taken (pred_taken),
        .upd_en   (branch_e_q),
        .upd_idx  (idx_e_q),
        .upd_taken(taken_e_q)
    );

endmodule

// File: tb/tb_hazard_predict_unit.sv
// Directed scoreboard bench for hazard_predict_unit: each stimulus cycle queues the
// hand-computed output vector, and a negedge monitor pops and compares it.
module tb_hazard_predict_unit;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
        logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
        logic       branchD, equalD;
        logic [5:0] pcD;
    } in_t;

    typedef struct packed {
        logic       stallF, stallD, flushD, flushE, fwdAD, fwdBD;
        logic [1:0] fwdAE, fwdBE;
        logic       brbitF, branchCorrect;
        logic [1:0] brmuxsel;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, equalD;
    logic [5:0] pcD;
    logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE, brmuxsel;
    logic       brbitF, branchCorrect;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hazard_predict_unit #(.IDXW(6)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .equalD(equalD), .pcD(pcD),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .brbitF(brbitF), .branchCorrect(branchCorrect), .brmuxsel(brmuxsel)
    );

    // Drives one cycle of inputs just after the rising edge and queues the expectation.
    task automatic applyStimulus(input in_t v, input out_t e, input string name);
        @(posedge clk);
        #1;
        reset     = v.rstn;
        rsD       = v.rsD;       rtD       = v.rtD;
        rsE       = v.rsE;       rtE       = v.rtE;
        writeregE = v.writeregE; writeregM = v.writeregM; writeregW = v.writeregW;
        regwriteE = v.regwriteE; regwriteM = v.regwriteM; regwriteW = v.regwriteW;
        memtoregE = v.memtoregE; memtoregM = v.memtoregM;
        branchD   = v.branchD;   equalD    = v.equalD;    pcD       = v.pcD;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input out_t e, input string name);
        out_t a;
        a = '{stallF: stallF, stallD: stallD, flushD: flushD, flushE: flushE,
              fwdAD: forwardAD, fwdBD: forwardBD, fwdAE: forwardAE, fwdBE: forwardBE,
              brbitF: brbitF, branchCorrect: branchCorrect, brmuxsel: brmuxsel};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b (stF stD flD flE fAD fBD fAE fBE brbit corr mux)",
                     name, a, e);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front(), name_q.pop_front());
            end
        end
    end

    // Bench-side reference: a branch resolved in E that was mispredicted.
    function automatic out_t mispredict_out(input logic taken);
        out_t e = '0;
        e.flushD   = 1'b1;
        e.flushE   = 1'b1;
        e.brmuxsel = taken ? 2'b01 : 2'b10;
        return e;
    endfunction

    function automatic in_t br(input logic [5:0] pc, input logic eq);
        in_t v = '0;
        v.rstn    = 1'b1;
        v.branchD = 1'b1;
        v.pcD     = pc;
        v.equalD  = eq;
        return v;
    endfunction

    initial begin : stimulus
        in_t  v, idle, rst;
        out_t e, z, stall_out, pred_t, correct;
        int   wait_cycles;

        z = '0;
        stall_out = '0;
        stall_out.stallF = 1'b1; stall_out.stallD = 1'b1; stall_out.flushE = 1'b1;
        pred_t = '0;  pred_t.brbitF = 1'b1;
        correct = '0; correct.branchCorrect = 1'b1;
        rst  = '0;
        idle = '0;    idle.rstn = 1'b1;

        reset = 1'b0;
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, equalD} = '0;
        pcD = '0;

        applyStimulus(rst,  z, "reset_state");
        applyStimulus(rst,  z, "reset_state2");
        applyStimulus(idle, z, "idle_after_reset");

        v = idle; v.memtoregE = 1'b1; v.rtE = 5'd5; v.rsD = 5'd5;
        applyStimulus(v, stall_out, "load_use_rs");
        v = idle; v.memtoregE = 1'b1; v.rtE = 5'd0; v.rsD = 5'd0;
        applyStimulus(v, z, "load_use_r0");

        v = idle; v.regwriteM = 1'b1; v.writeregM = 5'd3; v.regwriteW = 1'b1;
        v.writeregW = 5'd3; v.rsE = 5'd3;
        e = z; e.fwdAE = 2'b10;
        applyStimulus(v, e, "fwd_m_priority");
        v = idle; v.regwriteM = 1'b1; v.writeregM = 5'd0; v.regwriteW = 1'b1;
        v.writeregW = 5'd0;
        applyStimulus(v, z, "fwd_r0");
        v = idle; v.regwriteM = 1'b1; v.writeregM = 5'd12; v.rtE = 5'd12;
        v.regwriteW = 1'b1; v.writeregW = 5'd13; v.rsE = 5'd13; v.rsD = 5'd13; v.rtD = 5'd12;
        e = z; e.fwdAE = 2'b01; e.fwdBE = 2'b10; e.fwdBD = 1'b1;
        applyStimulus(v, e, "fwd_mixed");
        v = idle; v.regwriteM = 1'b1; v.writeregM = 5'd9; v.rsD = 5'd9; v.rtD = 5'd9;
        e = z; e.fwdAD = 1'b1; e.fwdBD = 1'b1;
        applyStimulus(v, e, "fwd_decode");

        applyStimulus(br(6'd7, 1'b1), z,                    "cold_branch_pred");
        applyStimulus(idle,           mispredict_out(1'b1), "cold_branch_resolve");
        applyStimulus(br(6'd7, 1'b1), pred_t,               "ctr10_pred");
        applyStimulus(idle,           correct,              "ctr10_correct");
        applyStimulus(br(6'd7, 1'b1), pred_t,               "ctr11_pred");
        applyStimulus(idle,           correct,              "ctr11_correct");
        applyStimulus(br(6'd8, 1'b1), z,                    "other_idx_pred");
        applyStimulus(idle,           mispredict_out(1'b1), "other_idx_resolve");
        applyStimulus(br(6'd7, 1'b0), pred_t,               "ctr11_sat_pred");
        applyStimulus(idle,           mispredict_out(1'b0), "trained_not_taken");
        applyStimulus(br(6'd7, 1'b0), pred_t,               "ctr10_after_nt");
        applyStimulus(idle,           mispredict_out(1'b0), "ctr10_nt_resolve");
        applyStimulus(br(6'd7, 1'b0), z,                    "ctr01_pred");
        applyStimulus(idle,           correct,              "ctr01_correct");
        applyStimulus(br(6'd7, 1'b0), z,                    "ctr00_pred");
        applyStimulus(idle,           correct,              "ctr00_correct");
        applyStimulus(br(6'd7, 1'b1), z,                    "ctr00_sat_pred");
        applyStimulus(idle,           mispredict_out(1'b1), "ctr00_sat_resolve");

        applyStimulus(br(6'd7, 1'b1), z, "mp_setup");
        v = br(6'd8, 1'b1); v.memtoregE = 1'b1; v.rtE = 5'd5; v.rsD = 5'd5;
        applyStimulus(v, mispredict_out(1'b1), "mispredict_beats_lwstall");
        applyStimulus(idle, z, "after_flush");

        v = br(6'd8, 1'b1); v.rsD = 5'd4; v.regwriteE = 1'b1; v.writeregE = 5'd4;
        applyStimulus(v, stall_out, "branch_stall_e");
        applyStimulus(v, stall_out, "branch_stall_hold");
        applyStimulus(idle, z, "branch_stall_no_update");
        v = br(6'd8, 1'b1); v.rtD = 5'd6; v.memtoregM = 1'b1; v.writeregM = 5'd6;
        applyStimulus(v, stall_out, "branch_stall_load_m");
        applyStimulus(idle, z, "branch_stall_m_clear");

        applyStimulus(br(6'd8, 1'b0), pred_t, "pre_reset_pred");
        applyStimulus(rst,  z, "reset_discards_branch");
        applyStimulus(idle, z, "post_reset_idle");
        applyStimulus(br(6'd8, 1'b1), z, "post_reset_ctr01");
        applyStimulus(idle, mispredict_out(1'b1), "post_reset_resolve");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
